// File: rtl/alu_pkg.sv
// Shared encodings for the EX-stage ALU: alu_op values, funct fields, internal
// control codes and the execution FSM states.
package alu_pkg;

  localparam logic [1:0] AluOpAdd = 2'b00;
  localparam logic [1:0] AluOpSub = 2'b01;

  localparam logic [5:0] FunctAdd   = 6'b100000;
  localparam logic [5:0] FunctSub   = 6'b100010;
  localparam logic [5:0] FunctAnd   = 6'b100100;
  localparam logic [5:0] FunctOr    = 6'b100101;
  localparam logic [5:0] FunctXor   = 6'b100110;
  localparam logic [5:0] FunctNor   = 6'b100111;
  localparam logic [5:0] FunctSlt   = 6'b101010;
  localparam logic [5:0] FunctSltu  = 6'b101011;
  localparam logic [5:0] FunctMfhi  = 6'b010000;
  localparam logic [5:0] FunctMflo  = 6'b010010;
  localparam logic [5:0] FunctMult  = 6'b011000;
  localparam logic [5:0] FunctMultu = 6'b011001;

  typedef logic [3:0] ctrl_t;

  // The first five codes keep the legacy decoder values.
  localparam ctrl_t CtrlAnd     = 4'b0000;
  localparam ctrl_t CtrlOr      = 4'b0001;
  localparam ctrl_t CtrlAdd     = 4'b0010;
  localparam ctrl_t CtrlSub     = 4'b0110;
  localparam ctrl_t CtrlSlt     = 4'b0111;
  localparam ctrl_t CtrlXor     = 4'b0011;
  localparam ctrl_t CtrlSltu    = 4'b1000;
  localparam ctrl_t CtrlMfhi    = 4'b1001;
  localparam ctrl_t CtrlMflo    = 4'b1010;
  localparam ctrl_t CtrlMult    = 4'b1011;
  localparam ctrl_t CtrlNor     = 4'b1100;
  localparam ctrl_t CtrlMultu   = 4'b1101;
  localparam ctrl_t CtrlIllegal = 4'b1111;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StMul  = 2'b01,
    StFix  = 2'b10,
    StDone = 2'b11
  } state_e;

  function automatic logic ctrl_is_mul(ctrl_t c);
    return (c == CtrlMult) || (c == CtrlMultu);
  endfunction

endpackage

// File: rtl/alu_exec_unit_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle for WIDTH cycles.
// The product register is {acc, multiplier}, shifted right each step.
module alu_mul_iter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             run_q, run_d;
  logic [WIDTH:0]   step_sum;

  assign step_sum  = {1'b0, acc_q} + {1'b0, (mplier_q[0] ? mcand_q : '0)};
  assign last_o    = run_q && (cnt_q == '0);
  assign product_o = {acc_q, mplier_q};

  always_comb begin
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    run_d    = run_q;
    if (start_i) begin
      mcand_d  = a_i;
      acc_d    = '0;
      mplier_d = b_i;
      cnt_d    = CntW'(WIDTH - 1);
      run_d    = 1'b1;
    end else if (run_q) begin
      acc_d    = step_sum[WIDTH:1];
      mplier_d = {step_sum[0], mplier_q[WIDTH-1:1]};
      cnt_d    = cnt_q - 1'b1;
      run_d    = (cnt_q != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      run_q    <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      run_q    <= run_d;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Registered EX-stage ALU with valid/ready on both sides; decodes alu_op/funct,
// executes single-cycle ops directly and mult/multu through the iterative core.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned FUNCT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [1:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result,
  output logic               zero,
  output logic               ovf,
  output logic               illegal,
  output logic               busy,
  output logic [WIDTH-1:0]   hi,
  output logic [WIDTH-1:0]   lo
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             illegal_q, illegal_d;
  logic             neg_q, neg_d;

  ctrl_t            ctrl;
  logic [WIDTH-1:0] sum, diff;
  logic [WIDTH-1:0] exec_res;
  logic             exec_ovf, exec_ill;
  logic             take;
  logic             mul_start, mul_signed, mul_last;
  logic [WIDTH-1:0] mul_a, mul_b;
  logic [2*WIDTH-1:0] mul_prod, prod_fix;

  always_comb begin
    ctrl = CtrlIllegal;
    case (alu_op)
      AluOpAdd: ctrl = CtrlAdd;
      AluOpSub: ctrl = CtrlSub;
      default: begin
        case (funct)
          FUNCT_W'(FunctAdd):   ctrl = CtrlAdd;
          FUNCT_W'(FunctSub):   ctrl = CtrlSub;
          FUNCT_W'(FunctAnd):   ctrl = CtrlAnd;
          FUNCT_W'(FunctOr):    ctrl = CtrlOr;
          FUNCT_W'(FunctXor):   ctrl = CtrlXor;
          FUNCT_W'(FunctNor):   ctrl = CtrlNor;
          FUNCT_W'(FunctSlt):   ctrl = CtrlSlt;
          FUNCT_W'(FunctSltu):  ctrl = CtrlSltu;
          FUNCT_W'(FunctMfhi):  ctrl = CtrlMfhi;
          FUNCT_W'(FunctMflo):  ctrl = CtrlMflo;
          FUNCT_W'(FunctMult):  ctrl = CtrlMult;
          FUNCT_W'(FunctMultu): ctrl = CtrlMultu;
          default:              ctrl = CtrlIllegal;
        endcase
      end
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    exec_res = '0;
    exec_ovf = 1'b0;
    exec_ill = 1'b0;
    case (ctrl)
      CtrlAdd: begin
        exec_res = sum;
        exec_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      CtrlSub: begin
        exec_res = diff;
        exec_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      CtrlAnd:  exec_res = a & b;
      CtrlOr:   exec_res = a | b;
      CtrlXor:  exec_res = a ^ b;
      CtrlNor:  exec_res = ~(a | b);
      CtrlSlt:  exec_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      CtrlSltu: exec_res = {{(WIDTH-1){1'b0}}, (a < b)};
      CtrlMfhi: exec_res = hi_q;
      CtrlMflo: exec_res = lo_q;
      CtrlMult, CtrlMultu: exec_res = '0;
      default:  exec_ill = 1'b1;
    endcase
  end

  // Signed multiply runs on magnitudes; the sign is reapplied in StFix.
  assign mul_signed = (ctrl == CtrlMult);
  assign mul_a      = (mul_signed && a[WIDTH-1]) ? -a : a;
  assign mul_b      = (mul_signed && b[WIDTH-1]) ? -b : b;
  assign prod_fix   = neg_q ? -mul_prod : mul_prod;

  alu_mul_iter #(
    .WIDTH(WIDTH)
  ) u_mul (
    .clk_i    (clk),
    .rst_ni   (rst_n),
    .start_i  (mul_start),
    .a_i      (mul_a),
    .b_i      (mul_b),
    .last_o   (mul_last),
    .product_o(mul_prod)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    zero_d    = zero_q;
    ovf_d     = ovf_q;
    illegal_d = illegal_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    neg_d     = neg_q;
    in_ready  = 1'b0;
    take      = 1'b0;
    mul_start = 1'b0;

    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        take     = in_valid;
      end
      StMul: begin
        if (mul_last) state_d = StFix;
      end
      StFix: begin
        hi_d      = prod_fix[2*WIDTH-1:WIDTH];
        lo_d      = prod_fix[WIDTH-1:0];
        result_d  = prod_fix[WIDTH-1:0];
        zero_d    = (prod_fix[WIDTH-1:0] == '0);
        ovf_d     = 1'b0;
        illegal_d = 1'b0;
        state_d   = StDone;
      end
      StDone: begin
        in_ready = out_ready;
        if (out_ready) begin
          take    = in_valid;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (take) begin
      if (ctrl_is_mul(ctrl)) begin
        mul_start = 1'b1;
        neg_d     = mul_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
        state_d   = StMul;
      end else begin
        result_d  = exec_res;
        zero_d    = (exec_res == '0);
        ovf_d     = exec_ovf;
        illegal_d = exec_ill;
        state_d   = StDone;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      result_q  <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      illegal_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      zero_q    <= zero_d;
      ovf_q     <= ovf_d;
      illegal_q <= illegal_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
    end
  end

  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StMul);
  assign result    = result_q;
  assign zero      = zero_q;
  assign ovf       = ovf_q;
  assign illegal   = illegal_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: expected results are queued when an op
// is driven and compared when the unit hands the result over.
module tb_alu_exec_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   alu_op = '0;
  logic [5:0]   funct = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         zero, ovf, illegal, busy;
  logic [W-1:0] hi, lo;

  alu_exec_unit #(
    .WIDTH  (W),
    .FUNCT_W(6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_op   (alu_op),
    .funct    (funct),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .zero     (zero),
    .ovf      (ovf),
    .illegal  (illegal),
    .busy     (busy),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         o;
    logic         ill;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         sb[$];
  int           total = 0;
  int           bad = 0;
  logic [W-1:0] mhi = '0;
  logic [W-1:0] mlo = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // Drive one op, wait (bounded) for acceptance, return at accept edge + 1.
  task automatic send(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                      input logic [W-1:0] y, input bit track, output int waited);
    exp_t        e;
    logic [W:0]  sx;
    logic [63:0] p;
    logic [W-1:0] r;
    bit          ill, ov, ismul, arith, dosub;
    r = '0; ill = 0; ov = 0; ismul = 0; arith = 0; dosub = 0; p = '0;
    if (op == 2'b00) arith = 1;
    else if (op == 2'b01) begin arith = 1; dosub = 1; end
    else begin
      case (fn)
        6'h20: arith = 1;
        6'h22: begin arith = 1; dosub = 1; end
        6'h24: r = x & y;
        6'h25: r = x | y;
        6'h26: r = x ^ y;
        6'h27: r = ~(x | y);
        6'h2a: r = ($signed(x) < $signed(y)) ? 1 : 0;
        6'h2b: r = (x < y) ? 1 : 0;
        6'h10: r = mhi;
        6'h12: r = mlo;
        6'h18: begin
          ismul = 1;
          p = $signed({{W{x[W-1]}}, x}) * $signed({{W{y[W-1]}}, y});
        end
        6'h19: begin ismul = 1; p = {32'b0, x} * {32'b0, y}; end
        default: ill = 1;
      endcase
    end
    if (arith) begin
      sx = dosub ? ({x[W-1], x} - {y[W-1], y}) : ({x[W-1], x} + {y[W-1], y});
      r  = sx[W-1:0];
      ov = sx[W] ^ sx[W-1];
    end
    if (ismul && track) begin
      mhi = p[63:32];
      mlo = p[31:0];
      r   = mlo;
    end
    e = '{res: r, z: (r == '0), o: ov, ill: ill, hi: mhi, lo: mlo};
    if (track) sb.push_back(e);

    alu_op = op; funct = fn; a = x; b = y; in_valid = 1'b1;
    waited = 0;
    @(negedge clk);
    while (!in_ready && waited <= 200) begin
      waited++;
      @(negedge clk);
    end
    if (waited > 200) check("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    alu_op = 2'($urandom); funct = 6'($urandom); a = $urandom; b = $urandom;
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) check("sb_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        check("res", result, e.res);
        check("zero", zero, e.z);
        check("ovf", ovf, e.o);
        check("illegal", illegal, e.ill);
        check("hi", hi, e.hi);
        check("lo", lo, e.lo);
      end
    end
  end

  initial begin
    int  w, n;
    bit  ir_bad;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_result", result, 0);
    check("rst_flags", {zero, ovf, illegal}, 0);
    check("rst_hilo", {hi, lo}, 0);
    rst_n = 1'b1;

    send(2'b00, 6'h00, 32'h7FFFFFFF, 32'h1, 1, w);
    check("add_valid_e0", out_valid, 1);
    check("add_result", result, 32'h80000000);
    check("add_ovf", ovf, 1);
    send(2'b10, 6'h22, 32'd5, 32'd5, 1, w);
    send(2'b10, 6'h2a, 32'hFFFFFFFF, 32'h1, 1, w);
    send(2'b11, 6'h2b, 32'hFFFFFFFF, 32'h1, 1, w);
    send(2'b10, 6'h27, 32'h0, 32'h0, 1, w);
    send(2'b10, 6'h24, 32'hF0F0_1234, 32'h0FF0_FF00, 1, w);
    send(2'b10, 6'h26, 32'hA5A5_A5A5, 32'hFFFF_0000, 1, w);
    send(2'b01, 6'h20, 32'h8000_0000, 32'h1, 1, w);

    // Signed multiply timing: busy for W cycles, result one edge later.
    send(2'b10, 6'h18, 32'hFFFFFFFD, 32'd7, 1, w);
    n = 0; ir_bad = 0;
    while (busy && n < 100) begin
      if (in_ready) ir_bad = 1;
      @(posedge clk);
      #1;
      n++;
    end
    check("mult_busy_cycles", n, W);
    check("mult_in_ready_low", ir_bad, 0);
    check("mult_valid_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("mult_valid_e33", out_valid, 1);
    check("mult_hi", hi, 32'hFFFFFFFF);
    check("mult_lo", lo, 32'hFFFFFFEB);
    send(2'b10, 6'h12, 32'h0, 32'h0, 1, w);

    send(2'b10, 6'h19, 32'hFFFFFFFF, 32'h2, 1, w);
    send(2'b10, 6'h10, 32'h0, 32'h0, 1, w);
    send(2'b10, 6'h18, 32'h8000_0000, 32'hFFFF_FFFF, 1, w);
    send(2'b10, 6'h10, 32'h0, 32'h0, 1, w);
    send(2'b10, 6'h19, 32'h1234_5678, 32'h9ABC_DEF0, 1, w);
    send(2'b10, 6'h10, 32'h0, 32'h0, 1, w);
    repeat (2) @(posedge clk);
    #1;

    // Backpressure: result must hold and no new op may be accepted.
    out_ready = 1'b0;
    send(2'b00, 6'h00, 32'h12, 32'h34, 1, w);
    for (int i = 0; i < 5; i++) begin
      check("bp_result", result, 32'h46);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send(2'b10, 6'h3F, 32'h55, 32'h66, 1, w);
    check("bp_same_edge", w, 0);
    check("illegal_flag", illegal, 1);
    check("illegal_result", result, 0);

    // Reset in the middle of a multiply.
    send(2'b10, 6'h18, 32'd5, 32'd6, 0, w);
    repeat (8) @(posedge clk);
    #1;
    check("mid_busy", busy, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    mhi = '0; mlo = '0;
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_hilo", {hi, lo}, 0);
    rst_n = 1'b1;
    send(2'b10, 6'h10, 32'h0, 32'h0, 1, w);
    send(2'b10, 6'h12, 32'h0, 32'h0, 1, w);
    send(2'b10, 6'h19, 32'd3, 32'd4, 1, w);
    send(2'b10, 6'h12, 32'h0, 32'h0, 1, w);

    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
